// File: rtl/mult_issue_ctrl.sv
// Issue/collect stage around a combinational array multiplier: registers
// operands onto the array, waits a settle window, then hands the product on.
module mult_issue_ctrl #(
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_signed,
   output logic [WIDTH-1:0]   arr_a,
   output logic [WIDTH-1:0]   arr_b,
   output logic               arr_signed,
   input  logic [2*WIDTH-1:0] arr_p,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic               out_signed,
   output logic               busy
);

   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

   generate
      if (SETTLE_CYCLES < 1) begin : g_bad_settle
         $error("SETTLE_CYCLES must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_HOLD
   } state_e;

   state_e             state_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   arr_a_q;
   logic [WIDTH-1:0]   arr_b_q;
   logic               arr_signed_q;
   logic [2*WIDTH-1:0] out_p_q;
   logic               out_signed_q;
   logic               accept;

   // A HOLD slot frees up in the same edge the product is taken.
   assign in_ready = !rst &&
                     ((state_q == S_IDLE) ||
                      ((state_q == S_HOLD) && out_ready));
   assign accept   = in_valid && in_ready;

   assign out_valid  = (state_q == S_HOLD);
   assign busy       = (state_q != S_IDLE);
   assign arr_a      = arr_a_q;
   assign arr_b      = arr_b_q;
   assign arr_signed = arr_signed_q;
   assign out_p      = out_p_q;
   assign out_signed = out_signed_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         arr_a_q      <= '0;
         arr_b_q      <= '0;
         arr_signed_q <= 1'b0;
         out_p_q      <= '0;
         out_signed_q <= 1'b0;
      end else if (accept) begin
         arr_a_q      <= in_a;
         arr_b_q      <= in_b;
         arr_signed_q <= in_signed;
         cnt_q        <= CNT_INIT;
         state_q      <= S_SETTLE;
      end else begin
         unique case (state_q)
            S_IDLE: ;
            S_SETTLE: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  out_p_q      <= arr_p;
                  out_signed_q <= arr_signed_q;
                  state_q      <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (out_ready) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mult_issue_ctrl.md
Name: mult_issue_ctrl

Overview:
- Sequential issue/collect stage wrapped around the combinational signed/unsigned array multiplier built from XOR-toggle full-adder cells.
- Accepts operand pairs over a valid/ready handshake and registers them onto the array inputs.
- Drives the array's signed-mode toggle, and holds operands stable for a fixed multicycle settle window.
- Captures the array product and presents it downstream over a valid/ready handshake.

Parameters:
- WIDTH, 8, operand width in bits; product width is 2*WIDTH.
- SETTLE_CYCLES, 2, cycles the array is given to settle; must be >= 1 (elaboration error otherwise).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1 = two's-complement multiply, 0 = unsigned.
- arr_a  out  WIDTH  registered multiplicand to array.
- arr_b  out  WIDTH  registered multiplier to array.
- arr_signed  out  1  registered toggle enable to array XOR cells.
- arr_p  in  2*WIDTH  combinational product from array.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.
- out_p  out  2*WIDTH  registered product.
- out_signed  out  1  mode of the product on out_p.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE; arr_a, arr_b, arr_signed, out_p, out_signed and the settle counter all 0; out_valid=0.
  - in_ready=0 while rst is high; in_ready=1 on the first cycle after rst deasserts.
- States are IDLE, SETTLE, HOLD.
- Combinational outputs:
  - in_ready = (state==IDLE) | (state==HOLD & out_ready).
  - out_valid = (state==HOLD).
  - busy = (state!=IDLE).
- Accept occurs at an edge where in_valid & in_ready. On accept:
  - arr_a<=in_a, arr_b<=in_b, arr_signed<=in_signed.
  - cnt<=SETTLE_CYCLES-1.
  - state<=SETTLE.
- arr_* change only on accept. They stay stable through SETTLE and HOLD.
- SETTLE:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: out_p<=arr_p, out_signed<=arr_signed, state<=HOLD.
  - SETTLE lasts exactly SETTLE_CYCLES cycles.
- Latency: accept at edge N gives out_valid=1 in the cycle after edge N+SETTLE_CYCLES.
- Throughput is one product per SETTLE_CYCLES+1 cycles with out_ready held high.
- HOLD:
  - out_p and out_signed are held stable until out_valid & out_ready.
  - On handshake with in_valid=1: accept the new pair in the same edge, go to SETTLE. out_p holds its old value until the next capture.
  - On handshake with in_valid=0: go to IDLE.
  - Without out_ready: remain in HOLD indefinitely, no data loss.
- in_valid, in_a, in_b and in_signed are ignored while in_ready=0. X on the data inputs outside an accept must not propagate.
- The block performs no arithmetic. out_p is arr_p sampled verbatim.
- Counter width is $clog2(SETTLE_CYCLES) with a minimum of 1 bit.
- Reset mid-SETTLE or mid-HOLD aborts the operation: the in-flight product is discarded and out_valid=0 on the next cycle.
- SETTLE_CYCLES=1: SETTLE lasts one cycle and cnt is always 0.

Test Plan:
- WIDTH=8, SETTLE_CYCLES=2, behavioural array model; send in_signed=1, a=0xFD(-3), b=0x05 -> out_valid 3 cycles after the accept edge, out_p=0xFFF1, out_signed=1.
- Unsigned a=0xFD, b=0x05 -> out_p=0x04F1. Unsigned 0xFF*0xFF -> out_p=0xFE01. Signed 0x80*0x80 -> out_p=0x4000.
- Hold out_ready=0 for 10 cycles after out_valid -> out_p, out_valid, arr_a and arr_b stable, in_ready=0. Then assert out_ready with in_valid=1 -> same-edge accept, next product follows SETTLE_CYCLES later.
- Stream 4 back-to-back ops with out_ready=1 -> one result every 3 cycles, in order, no drop or duplication. Repeat with SETTLE_CYCLES=1 -> one result every 2 cycles.
- Assert rst for one cycle during SETTLE -> next cycle out_valid=0, busy=0, in_ready=1, all registers 0. The aborted product never appears.
- Drive in_valid=1 with changing data while the block is in SETTLE -> arr_a and arr_b are unchanged, and only the pairs presented at handshake edges are processed.
